// File: rtl/sign_pkg.sv
// sign_pkg: lamp encodings, boolean constants, phase state encodings and the state-to-lamp decode
package sign_pkg;
  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN = 2'd2;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic [2:0] {
    MAIN_GRN  = 3'd0,
    MAIN_YEL  = 3'd1,
    ALL_RED1  = 3'd2,
    PED_WALK  = 3'd3,
    CNTRY_GRN = 3'd4,
    CNTRY_YEL = 3'd5,
    ALL_RED2  = 3'd6
  } state_t;
  typedef struct packed {
    logic [1:0] main_sig;
    logic [1:0] cntry_sig;
    logic       walk;
  } lamp_t;
  function automatic lamp_t lamp_decode(input state_t s);
    lamp_t l;
    l.main_sig = s == MAIN_GRN ? GREEN : s == MAIN_YEL ? YELLOW : RED;
    l.cntry_sig = s == CNTRY_GRN ? GREEN : s == CNTRY_YEL ? YELLOW : RED;
    l.walk = s == PED_WALK;
    return l;
  endfunction
endpackage

// File: rtl/sign_phase_timer.sv
// sign_phase_timer: phase down-counter holding at 0 (CLOCK, CLEAR async, load/load_val in, expired out)
module sign_phase_timer #(
  parameter int TIMER_W = 8,
  parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
  input  logic               CLOCK,
  input  logic               CLEAR,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);
  logic [TIMER_W-1:0] timer_q, timer_d;
  assign expired = timer_q == '0;
  always_comb timer_d = load ? load_val : expired ? timer_q : timer_q - TIMER_W'(1);
  always_ff @(posedge CLOCK or posedge CLEAR)
    if (CLEAR) timer_q <= RST_VAL;
    else timer_q <= timer_d;
endmodule

// File: rtl/sign_phase_sched.sv
// sign_phase_sched: intersection phase scheduler (CLOCK, CLEAR, CAR_ON_CNTRY_RD, PED_REQ in; MAIN_SIG, CNTRY_SIG, WALK, PED_PENDING, STATE out)
module sign_phase_sched
  import sign_pkg::*;
#(
  parameter int TIMER_W = 8,
  parameter int MIN_MAIN_GRN = 20,
  parameter int MAX_CNTRY_GRN = 15,
  parameter int YEL_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME = 10
) (
  input  logic       CLOCK,
  input  logic       CLEAR,
  input  logic       CAR_ON_CNTRY_RD,
  input  logic       PED_REQ,
  output logic [1:0] MAIN_SIG,
  output logic [1:0] CNTRY_SIG,
  output logic       WALK,
  output logic       PED_PENDING,
  output logic [2:0] STATE
);
  localparam int LIM = 1 << TIMER_W;
  if (MIN_MAIN_GRN < 1 || MIN_MAIN_GRN >= LIM || MAX_CNTRY_GRN < 1 || MAX_CNTRY_GRN >= LIM ||
      YEL_TIME < 1 || YEL_TIME >= LIM || ALLRED_TIME < 1 || ALLRED_TIME >= LIM ||
      WALK_TIME < 1 || WALK_TIME >= LIM) begin : g_bad_param
    $error("sign_phase_sched: every duration must be in 1 .. 2**TIMER_W-1");
  end
  state_t state_q, state_d;
  logic ped_q, ped_d;
  lamp_t lamp_q, lamp_d;
  logic expired, load;
  logic [TIMER_W-1:0] load_val;
  sign_phase_timer #(
    .TIMER_W(TIMER_W),
    .RST_VAL(TIMER_W'(MIN_MAIN_GRN - 1))
  ) u_timer (
    .CLOCK(CLOCK),
    .CLEAR(CLEAR),
    .load(load),
    .load_val(load_val),
    .expired(expired)
  );
  always_comb begin
    case (state_q)
      MAIN_GRN:  state_d = expired && (CAR_ON_CNTRY_RD || ped_q) ? MAIN_YEL : MAIN_GRN;
      MAIN_YEL:  state_d = expired ? ALL_RED1 : MAIN_YEL;
      ALL_RED1:  state_d = !expired ? ALL_RED1 : ped_q ? PED_WALK : CNTRY_GRN;
      PED_WALK:  state_d = !expired ? PED_WALK : CAR_ON_CNTRY_RD ? CNTRY_GRN : MAIN_GRN;
      CNTRY_GRN: state_d = expired || !CAR_ON_CNTRY_RD ? CNTRY_YEL : CNTRY_GRN;
      CNTRY_YEL: state_d = expired ? ALL_RED2 : CNTRY_YEL;
      ALL_RED2:  state_d = expired ? MAIN_GRN : ALL_RED2;
      default:   state_d = MAIN_GRN;
    endcase
    load = state_d != state_q;
    load_val = state_d == MAIN_GRN ? TIMER_W'(MIN_MAIN_GRN - 1) :
               state_d == CNTRY_GRN ? TIMER_W'(MAX_CNTRY_GRN - 1) :
               state_d == PED_WALK ? TIMER_W'(WALK_TIME - 1) :
               state_d inside {MAIN_YEL, CNTRY_YEL} ? TIMER_W'(YEL_TIME - 1) : TIMER_W'(ALLRED_TIME - 1);
    ped_d = (ped_q | (PED_REQ & state_q != PED_WALK)) & ~(load & state_d == PED_WALK);
    lamp_d = lamp_decode(state_d);
  end
  always_ff @(posedge CLOCK or posedge CLEAR)
    if (CLEAR) begin
      state_q <= MAIN_GRN;
      ped_q <= FALSE;
      lamp_q <= lamp_decode(MAIN_GRN);
    end else begin
      state_q <= state_d;
      ped_q <= ped_d;
      lamp_q <= lamp_d;
    end
  assign MAIN_SIG = lamp_q.main_sig;
  assign CNTRY_SIG = lamp_q.cntry_sig;
  assign WALK = lamp_q.walk;
  assign PED_PENDING = ped_q;
  assign STATE = state_q;
  a_excl: assert property (@(posedge CLOCK) disable iff (CLEAR) MAIN_SIG == RED || CNTRY_SIG == RED);
  a_walk: assert property (@(posedge CLOCK) disable iff (CLEAR) WALK |-> MAIN_SIG == RED && CNTRY_SIG == RED);
  a_main_grn: assert property (@(posedge CLOCK) disable iff (CLEAR)
    MAIN_SIG == GREEN && $past(MAIN_SIG) != GREEN |-> $past(CNTRY_SIG) == RED);
  a_cntry_grn: assert property (@(posedge CLOCK) disable iff (CLEAR)
    CNTRY_SIG == GREEN && $past(CNTRY_SIG) != GREEN |-> $past(MAIN_SIG) == RED);
endmodule

// File: tb/tb_sign_phase_sched.sv
// tb_sign_phase_sched: randomized and directed checks of sign_phase_sched against an elapsed-time phase model
module tb_sign_phase_sched;
  localparam int MIN_MG = 20, MAX_CG = 15, YEL = 3, AR = 2, WLK = 10;
  logic CLOCK = 0, CLEAR = 1, CAR_ON_CNTRY_RD = 0, PED_REQ = 0;
  logic [1:0] MAIN_SIG, CNTRY_SIG;
  logic WALK, PED_PENDING;
  logic [2:0] STATE;
  int checks = 0, passes = 0;
  int ph = 0, age = 1;
  bit pend = 0;
  sign_phase_sched dut (
    .CLOCK(CLOCK),
    .CLEAR(CLEAR),
    .CAR_ON_CNTRY_RD(CAR_ON_CNTRY_RD),
    .PED_REQ(PED_REQ),
    .MAIN_SIG(MAIN_SIG),
    .CNTRY_SIG(CNTRY_SIG),
    .WALK(WALK),
    .PED_PENDING(PED_PENDING),
    .STATE(STATE)
  );
  always #5 CLOCK = ~CLOCK;
  function automatic int next_phase(int p, int a, bit car, bit pd);
    case (p)
      0: return a >= MIN_MG && (car || pd) ? 1 : 0;
      1: return a >= YEL ? 2 : 1;
      2: return a < AR ? 2 : pd ? 3 : 4;
      3: return a < WLK ? 3 : car ? 4 : 0;
      4: return !car || a >= MAX_CG ? 5 : 4;
      5: return a >= YEL ? 6 : 5;
      default: return a >= AR ? 0 : 6;
    endcase
  endfunction
  always @(posedge CLOCK or posedge CLEAR)
    if (CLEAR) begin
      ph <= 0;
      age <= 1;
      pend <= 0;
    end else begin
      ph <= next_phase(ph, age, CAR_ON_CNTRY_RD, pend);
      age <= next_phase(ph, age, CAR_ON_CNTRY_RD, pend) == ph ? age + 1 : 1;
      pend <= (pend || (PED_REQ && ph != 3)) && !(next_phase(ph, age, CAR_ON_CNTRY_RD, pend) == 3 && ph != 3);
    end
  function automatic int model_vec();
    int m, c;
    m = ph == 0 ? 2 : ph == 1 ? 1 : 0;
    c = ph == 4 ? 2 : ph == 5 ? 1 : 0;
    return (ph << 6) | (m << 4) | (c << 2) | ((ph == 3 ? 1 : 0) << 1) | (pend ? 1 : 0);
  endfunction
  task automatic check(string name, int got, int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask
  always @(negedge CLOCK)
    if (!CLEAR) check("cycle_model", int'({STATE, MAIN_SIG, CNTRY_SIG, WALK, PED_PENDING}), model_vec());
  task automatic tick(int n);
    repeat (n) @(negedge CLOCK);
  endtask
  task automatic restart();
    CLEAR = 1;
    tick(5);
    check("rst_outputs", int'({STATE, MAIN_SIG, CNTRY_SIG, WALK, PED_PENDING}), int'({3'd0, 2'd2, 2'd0, 1'b0, 1'b0}));
    CLEAR = 0;
  endtask
  initial begin
    restart();
    tick(300);
    check("t1_state", STATE, 0);
    check("t1_main", MAIN_SIG, 2);
    check("t1_walk", WALK, 0);
    restart();
    tick(5);
    CAR_ON_CNTRY_RD = 1;
    tick(14);
    check("t2_mgrn_last", STATE, 0);
    tick(1);
    check("t2_myel", STATE, 1);
    tick(5);
    check("t2_cgrn", CNTRY_SIG, 2);
    tick(14);
    check("t2_cgrn_last", STATE, 4);
    tick(1);
    check("t2_cyel", STATE, 5);
    tick(5);
    check("t2_mgrn_again", STATE, 0);
    tick(19);
    check("t2_mgrn_min", STATE, 0);
    tick(1);
    check("t2_myel_again", STATE, 1);
    CAR_ON_CNTRY_RD = 0;
    restart();
    CAR_ON_CNTRY_RD = 1;
    tick(28);
    check("t3_cgrn", STATE, 4);
    CAR_ON_CNTRY_RD = 0;
    tick(1);
    check("t3_cyel", CNTRY_SIG, 1);
    tick(3);
    check("t3_allred2", STATE, 6);
    tick(2);
    check("t3_mgrn", STATE, 0);
    restart();
    tick(3);
    PED_REQ = 1;
    tick(1);
    PED_REQ = 0;
    check("t4_pend", PED_PENDING, 1);
    tick(16);
    check("t4_myel", STATE, 1);
    tick(5);
    check("t4_walk_state", STATE, 3);
    check("t4_walk_lamp", int'({WALK, MAIN_SIG, CNTRY_SIG, PED_PENDING}), int'({1'b1, 2'd0, 2'd0, 1'b0}));
    tick(9);
    check("t4_walk_last", WALK, 1);
    tick(1);
    check("t4_mgrn", STATE, 0);
    restart();
    CAR_ON_CNTRY_RD = 1;
    tick(2);
    PED_REQ = 1;
    tick(1);
    PED_REQ = 0;
    tick(22);
    check("t5_walk", STATE, 3);
    tick(3);
    PED_REQ = 1;
    tick(1);
    PED_REQ = 0;
    check("t5_walk_req_ignored", PED_PENDING, 0);
    tick(6);
    check("t5_cgrn", STATE, 4);
    CAR_ON_CNTRY_RD = 0;
    restart();
    CAR_ON_CNTRY_RD = 1;
    tick(26);
    PED_REQ = 1;
    tick(1);
    PED_REQ = 0;
    tick(1);
    check("t6_pre_state", STATE, 4);
    check("t6_pre_pend", PED_PENDING, 1);
    #3 CLEAR = 1;
    #1 check("t6_async_clear", int'({STATE, MAIN_SIG, CNTRY_SIG, WALK, PED_PENDING}), int'({3'd0, 2'd2, 2'd0, 1'b0, 1'b0}));
    tick(5);
    CLEAR = 0;
    tick(19);
    check("t6_mgrn", STATE, 0);
    tick(1);
    check("t6_myel", STATE, 1);
    CAR_ON_CNTRY_RD = 0;
    restart();
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      if ($urandom_range(0, 24) == 0) CAR_ON_CNTRY_RD = ~CAR_ON_CNTRY_RD;
      PED_REQ = $urandom_range(0, 39) == 0;
      if (i == 2000) begin
        #3 CLEAR = 1;
        tick(2);
        CLEAR = 0;
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sign_phase_sched.md
Name: sign_phase_sched

Overview:
Timed phase scheduler for the highway/country-road intersection. It sequences MAIN_SIG and CNTRY_SIG through green, yellow and all-red phases using programmable cycle counts. Phase changes are driven by the country-road car sensor and a latched pedestrian request. It is the timing/arbitration successor to the basic sign_contr controller. It sits between the road sensors and the lamp drivers.

Parameters:
TIMER_W, 8, phase timer width; every duration must be < 2**TIMER_W
MIN_MAIN_GRN, 20, minimum main-green cycles
MAX_CNTRY_GRN, 15, maximum country-green cycles
YEL_TIME, 3, yellow cycles (both roads)
ALLRED_TIME, 2, all-red clearance cycles
WALK_TIME, 10, pedestrian walk cycles

Ports:
CLOCK  in  1  single system clock, rising edge
CLEAR  in  1  reset, asynchronous, active-high
CAR_ON_CNTRY_RD  in  1  country-road car sensor, level
PED_REQ  in  1  pedestrian button, pulse or level
MAIN_SIG  out  2  highway lamp: RED=2'd0, YELLOW=2'd1, GREEN=2'd2
CNTRY_SIG  out  2  country lamp, same encoding
WALK  out  1  pedestrian walk lamp
PED_PENDING  out  1  latched pedestrian request
STATE  out  3  current FSM state (debug)

Behaviour:
- Reset (CLEAR=1, async): state=MAIN_GRN, timer loaded with MIN_MAIN_GRN-1, MAIN_SIG=GREEN, CNTRY_SIG=RED, WALK=0, PED_PENDING=0, STATE=0.
- All outputs are registered. They are a pure decode of the state register, so they change on the same edge as the state.
- Timer: loaded with D-1 on each state entry, where D is the state's duration. It decrements each cycle and holds at 0. expired = (timer==0), so a fixed-length state lasts exactly D cycles.
- States (encoding 0..6):
  - MAIN_GRN (G/R): leave only when expired AND (CAR_ON_CNTRY_RD OR PED_PENDING) at a sampling edge; that edge enters MAIN_YEL. When expired with no request, stay indefinitely.
  - MAIN_YEL (Y/R): YEL_TIME cycles, then ALL_RED1.
  - ALL_RED1 (R/R): ALLRED_TIME cycles, then PED_WALK if PED_PENDING, else CNTRY_GRN.
  - PED_WALK (R/R, WALK=1): WALK_TIME cycles, then CNTRY_GRN if CAR_ON_CNTRY_RD, else MAIN_GRN.
  - CNTRY_GRN (R/G): leave on the first edge where CAR_ON_CNTRY_RD=0 or expired (MAX_CNTRY_GRN reached); next is CNTRY_YEL. Minimum duration is 1 cycle.
  - CNTRY_YEL (R/Y): YEL_TIME cycles, then ALL_RED2.
  - ALL_RED2 (R/R): ALLRED_TIME cycles, then MAIN_GRN.
- Pedestrian latch: next = (PED_PENDING | (PED_REQ & state!=PED_WALK)) & ~enter_walk.
  - A request on the edge that enters PED_WALK is consumed.
  - Requests during PED_WALK are ignored.
  - Repeated requests are idempotent.
- Priority out of ALL_RED1: pedestrian first, then country.
- Safety invariants, checked by assertions:
  - Never both MAIN_SIG and CNTRY_SIG non-RED.
  - WALK=1 only when both are RED.
  - A GREEN is never entered directly from the other road's GREEN or YELLOW.
- Illegal state encodings (7) recover to MAIN_GRN on the next edge.
- CLEAR mid-phase: immediate return to reset values; the pending request is dropped.
- Elaboration error if any duration parameter is 0 or is ≥ 2**TIMER_W.

Decomposition:
- Shared package sign_pkg holds:
  - the lamp constants RED/YELLOW/GREEN;
  - TRUE/FALSE;
  - the 3-bit state encodings;
  - a lamp-decode function (state -> MAIN_SIG, CNTRY_SIG, WALK).
- One sub-module, sign_phase_timer: a TIMER_W down-counter with load, load value and expired output, async-cleared by CLEAR.
- The FSM and pedestrian latch stay in sign_phase_sched.

Test Plan:
1. Hold CLEAR for 5 negedges, then no car and no pedestrian for 300 cycles -> MAIN=GREEN and CNTRY=RED throughout; STATE=0; WALK=0.
2. After release, hold CAR_ON_CNTRY_RD=1 from cycle 5 -> expected sequence:
   - main green through cycle 20, then 3 yellow and 2 all-red;
   - country green exactly 15 cycles (cap), then 3 country yellow and 2 all-red;
   - main green again for at least 20 cycles before the next yellow.
3. Car present in MAIN_GRN; deassert it after 4 cycles of CNTRY_GRN -> CNTRY_SIG=YELLOW on the next edge, then ALL_RED2, then MAIN_GRN.
4. One-cycle PED_REQ at cycle 3 with no car -> PED_PENDING=1; at cycle 20 main yellow (3), all-red (2), WALK=1 for 10 cycles with both RED, PED_PENDING=0, then MAIN_GRN.
5. PED_REQ plus car held -> walk phase (10 cycles) precedes country green; a PED_REQ during walk is not latched (PED_PENDING stays 0).
6. Assert CLEAR asynchronously mid-CNTRY_GRN with PED_PENDING=1 -> same instant MAIN=GREEN, CNTRY=RED, WALK=0, PED_PENDING=0; the sequence restarts with a 20-cycle main green.
